// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset/run sequencer: state encoding and
// a helper for sizing the internal counters.
package rst_seq_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchroniser: assertion passes straight through,
// release is retimed onto clk_init over two edges.
module rst_sync (
  input  logic clk_init,
  input  logic rst_init,
  output logic rst_sync_o
);

  logic meta_q;
  logic sync_q;

  // Async set on rst_init, shift zeros in once it is released.
  always_ff @(posedge clk_init or posedge rst_init) begin
    if (rst_init) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= 1'b0;
      sync_q <= meta_q;
    end
  end

  assign rst_sync_o = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset and run-control sequencer: holds all channels in reset after
// board reset, releases them in staggered order, then supervises RUN
// (cycle count, halt detection, optional watchdog).
// Build option: define RST_SEQ_WDT_EN to include the RUN-phase watchdog.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int HOLD_CYCLES    = 100,
  parameter int STAGGER        = 4,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_W          = 32
) (
  input  logic              clk_init,
  input  logic              rst_init,
  input  logic              soft_rst_i,
  input  logic              halt_i,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              run_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  // The hold count includes the edge on which the synchronised reset
  // releases, so the FSM (first active one edge later) compares against
  // HOLD_CYCLES-1 to release channel 0 exactly HOLD_CYCLES edges after it.
  localparam int HOLD_W   = cnt_width(HOLD_CYCLES - 1);
  localparam int STAG_MAX = (NUM_CH - 1) * STAGGER;
  localparam int STAG_W   = cnt_width(STAG_MAX);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAG_MAX);
  localparam logic [CNT_W-1:0]  WDT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic rst_s;

  state_e             state_q,     state_d;
  logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
  logic [STAG_W-1:0]  stag_cnt_q,  stag_cnt_d;
  logic [NUM_CH-1:0]  rst_n_q,     rst_n_d;
  logic               run_q,       run_d;
  logic               done_q,      done_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;

  logic [STAG_W-1:0]  stag_next;
  logic [NUM_CH-1:0]  ch_hit;
  logic [CNT_W-1:0]   cnt_inc;

`ifdef RST_SEQ_WDT_EN
  logic               timeout_q,   timeout_d;
`else
  // TIMEOUT_CYCLES has no effect without the watchdog.
  logic               unused_wdt_limit;
  assign unused_wdt_limit = ^WDT_LAST;
`endif

  rst_sync u_rst_sync (
    .clk_init   (clk_init),
    .rst_init   (rst_init),
    .rst_sync_o (rst_s)
  );

  assign stag_next = stag_cnt_q + 1'b1;

  // Cycle counter saturates at all-ones instead of wrapping.
  assign cnt_inc = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + 1'b1;

  // Channel gi is released on the RELEASE edge whose stagger count hits gi*STAGGER.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_hit
    assign ch_hit[gi] = (stag_next == STAG_W'(gi * STAGGER));
  end

  // Next-state and next-output logic; soft reset outranks halt, halt outranks watchdog.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stag_cnt_d  = stag_cnt_q;
    rst_n_d     = rst_n_q;
    run_d       = run_q;
    done_d      = done_q;
    cycle_cnt_d = cycle_cnt_q;
`ifdef RST_SEQ_WDT_EN
    timeout_d   = timeout_q;
`endif

    if (soft_rst_i) begin
      // Re-sequence from scratch; in HOLD this simply restarts the hold count.
      state_d     = ST_HOLD;
      hold_cnt_d  = '0;
      stag_cnt_d  = '0;
      rst_n_d     = '0;
      run_d       = 1'b0;
      done_d      = 1'b0;
      cycle_cnt_d = '0;
`ifdef RST_SEQ_WDT_EN
      timeout_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            rst_n_d[0] = 1'b1;
            stag_cnt_d = '0;
            if (NUM_CH == 1) begin
              // A single channel's release is also the last release.
              state_d = ST_RUN;
              run_d   = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          stag_cnt_d = stag_next;
          rst_n_d    = rst_n_q | ch_hit;
          if (stag_next == STAG_LAST) begin
            state_d = ST_RUN;
            run_d   = 1'b1;
          end
        end

        ST_RUN: begin
          // The exit edge still counts as a RUN cycle, then the count freezes.
          cycle_cnt_d = cnt_inc;
          if (halt_i) begin
            state_d = ST_DONE;
            run_d   = 1'b0;
            done_d  = 1'b1;
          end
`ifdef RST_SEQ_WDT_EN
          else if (cycle_cnt_q == WDT_LAST) begin
            state_d   = ST_TIMEOUT;
            run_d     = 1'b0;
            timeout_d = 1'b1;
          end
`endif
        end

        default: begin
          // DONE / TIMEOUT: channels stay released, everything frozen.
        end
      endcase
    end
  end

  // State and registered outputs; assertion of rst_init clears them immediately.
  always_ff @(posedge clk_init or posedge rst_s) begin
    if (rst_s) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      stag_cnt_q  <= '0;
      rst_n_q     <= '0;
      run_q       <= 1'b0;
      done_q      <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stag_cnt_q  <= stag_cnt_d;
      rst_n_q     <= rst_n_d;
      run_q       <= run_d;
      done_q      <= done_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

`ifdef RST_SEQ_WDT_EN
  // Sticky watchdog flag, cleared only by reset or soft reset.
  always_ff @(posedge clk_init or posedge rst_s) begin
    if (rst_s) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign rst_n_o     = rst_n_q;
  assign run_o       = run_q;
  assign done_o      = done_q;
  assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl. Three instances share one clock:
//   a: defaults (power-on, halt at RUN cycle 500, soft reset from DONE, random halt)
//   w: TIMEOUT_CYCLES=16 (watchdog, soft reset, halt/timeout collision)
//   b: NUM_CH=4, HOLD_CYCLES=20, STAGGER=3 (async reset mid-RELEASE, soft reset in HOLD)
// Expected outputs come from an arithmetic model of edges since sequence start.
module tb_rst_seq_ctrl;

`ifdef RST_SEQ_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  localparam int W_SOFT = 300;             // soft reset of w driven here, sampled at 301
  localparam int W_HALT = 301 + 103 + 16;  // halt sampled at w's 16th RUN cycle

  typedef struct packed {
    logic [3:0]  rst_n;
    logic        run;
    logic        done;
    logic        timeout;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic soft_a, soft_w, soft_b;
  logic halt_a, halt_w, halt_b;

  logic [1:0]  rn_a, rn_w;
  logic [3:0]  rn_b;
  logic        run_a, run_w, run_b;
  logic        done_a, done_w, done_b;
  logic        tmo_a, tmo_w, tmo_b;
  logic [31:0] cnt_a, cnt_w, cnt_b;

  int total = 0;
  int bad   = 0;
  int g;                       // edge index, 0 = E0 of the power-on release
  int s_a, s_w, s_b;           // edge index at which each sequence (re)started
  int hr_a, hr_w;              // RUN cycle at which halt is sampled, -1 = none
  int hr2, ga_soft, ga_h2;
  int gb_rst, gb_dly, gb_soft;

  rst_seq_ctrl #(.NUM_CH(2), .HOLD_CYCLES(100), .STAGGER(4), .TIMEOUT_CYCLES(10000), .CNT_W(32)) u_a (
    .clk_init(clk), .rst_init(rst_a), .soft_rst_i(soft_a), .halt_i(halt_a),
    .rst_n_o(rn_a), .run_o(run_a), .done_o(done_a), .timeout_o(tmo_a), .cycle_cnt_o(cnt_a)
  );

  rst_seq_ctrl #(.NUM_CH(2), .HOLD_CYCLES(100), .STAGGER(4), .TIMEOUT_CYCLES(16), .CNT_W(32)) u_w (
    .clk_init(clk), .rst_init(rst_a), .soft_rst_i(soft_w), .halt_i(halt_w),
    .rst_n_o(rn_w), .run_o(run_w), .done_o(done_w), .timeout_o(tmo_w), .cycle_cnt_o(cnt_w)
  );

  rst_seq_ctrl #(.NUM_CH(4), .HOLD_CYCLES(20), .STAGGER(3), .TIMEOUT_CYCLES(10000), .CNT_W(32)) u_b (
    .clk_init(clk), .rst_init(rst_b), .soft_rst_i(soft_b), .halt_i(halt_b),
    .rst_n_o(rn_b), .run_o(run_b), .done_o(done_b), .timeout_o(tmo_b), .cycle_cnt_o(cnt_b)
  );

  // Outputs d edges after sequence start (d=0 is E0), halt at RUN cycle halt_r.
  function automatic exp_t model(input int nch, input int hold, input int stag, input int tmo,
                                 input bit wdt, input int d, input int halt_r);
    exp_t x;
    int   trun, r, stop;
    bit   halted;
    x = '0;
    if (d >= 0) begin
      for (int k = 0; k < nch; k++) x.rst_n[k] = (d >= hold + k * stag);
      trun = hold + (nch - 1) * stag;
      r    = d - trun;
      if (r >= 0) begin
        stop   = wdt ? tmo : 32'h7fffffff;
        halted = 1'b0;
        if (halt_r > 0 && halt_r <= stop) begin
          stop   = halt_r;
          halted = 1'b1;
        end
        x.cnt     = 32'((r < stop) ? r : stop);
        x.run     = (r < stop);
        x.done    = halted && (r >= stop);
        x.timeout = !halted && (r >= stop);
      end
    end
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    g++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, g, obs, exp_v);
    end
  endtask

  task automatic chk_dut(input string n, input logic [3:0] rn, input logic run, input logic done,
                         input logic tmo, input logic [31:0] cnt, input exp_t x);
    chk({n, ".rst_n"},   32'(rn),   32'(x.rst_n));
    chk({n, ".run"},     32'(run),  32'(x.run));
    chk({n, ".done"},    32'(done), 32'(x.done));
    chk({n, ".timeout"}, 32'(tmo),  32'(x.timeout));
    chk({n, ".cnt"},     cnt,       x.cnt);
  endtask

  task automatic chk_all();
    chk_dut("a", {2'b00, rn_a}, run_a, done_a, tmo_a, cnt_a, model(2, 100, 4, 10000, WDT, g - s_a, hr_a));
    chk_dut("w", {2'b00, rn_w}, run_w, done_w, tmo_w, cnt_w, model(2, 100, 4, 16, WDT, g - s_w, hr_w));
    chk_dut("b", rn_b, run_b, done_b, tmo_b, cnt_b, model(4, 20, 3, 10000, WDT, g - s_b, -1));
  endtask

  initial begin
    rst_a  = 1'b0; rst_b  = 1'b0;
    soft_a = 1'b0; soft_w = 1'b0; soft_b = 1'b0;
    halt_a = 1'b0; halt_w = 1'b0; halt_b = 1'b0;
    g = -2; s_a = 0; s_w = 0; s_b = 0;
    hr_a = -1; hr_w = -1;
    ga_h2 = -100; gb_soft = -100;
    hr2     = int'($urandom_range(1, 60));
    ga_soft = int'($urandom_range(610, 615));
    gb_rst  = int'($urandom_range(23, 25));
    gb_dly  = int'($urandom_range(1, 7));

    #2;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    $display("t=%0t reset asserted", $time);
    chk_all();

    #1047;
    rst_a = 1'b0; rst_b = 1'b0;
    $display("t=%0t rst_init released", $time);

    while (g < 820) begin
      tick();
      chk_all();

      // Instance a: halt at RUN cycle 500, soft reset from DONE, random halt.
      if (g == 603) begin
        halt_a = 1'b1; hr_a = 500;
        $display("t=%0t a: halt for RUN cycle 500", $time);
      end
      if (g == 604) halt_a = 1'b0;
      if (g == ga_soft) begin
        soft_a = 1'b1; s_a = g + 1; hr_a = -1;
        ga_h2  = s_a + 103 + hr2;
        $display("t=%0t a: soft reset from DONE, next halt at RUN cycle %0d", $time, hr2);
      end
      if (g == ga_soft + 1) soft_a = 1'b0;
      if (g == ga_h2) begin
        halt_a = 1'b1; hr_a = hr2;
        $display("t=%0t a: halt for RUN cycle %0d", $time, hr2);
      end
      if (g == ga_h2 + 1) halt_a = 1'b0;

      // Instance w: watchdog run, then soft reset and halt on the timeout edge.
      if (g == W_SOFT) begin
        soft_w = 1'b1; s_w = g + 1; hr_w = -1;
        $display("t=%0t w: soft reset", $time);
      end
      if (g == W_SOFT + 1) soft_w = 1'b0;
      if (g == W_HALT) begin
        halt_w = 1'b1; hr_w = 16;
        $display("t=%0t w: halt on timeout edge", $time);
      end
      if (g == W_HALT + 1) halt_w = 1'b0;

      // Instance b: async reset between edges after channel 1 is released.
      if (g == gb_rst) begin
        repeat (gb_dly) #1;
        rst_b = 1'b1; s_b = 1000000;
        #1;
        chk("b.async_rst_n", 32'(rn_b), 32'd0);
        $display("t=%0t b: async reset mid-RELEASE", $time);
      end
      if (g == gb_rst + 3) begin
        #3;
        rst_b = 1'b0; s_b = g + 2; gb_soft = s_b + 10;
        $display("t=%0t b: rst_init released", $time);
      end
      if (g == gb_soft) begin
        soft_b = 1'b1; s_b = g + 1;
        $display("t=%0t b: soft reset in HOLD", $time);
      end
      if (g == gb_soft + 1) soft_b = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Parametrised reset and run-control sequencer for the MiniMIPS32 SoC. It takes the raw board clock and reset, synchronises the reset release, and holds all downstream resets for a programmable interval. It then releases N reset channels (CPU, bus, peripherals) in staggered order and supervises the run phase with a cycle counter, halt detection and an optional watchdog timeout. It replaces the fixed delays and hard stop formerly hand-coded in the SoC bench, and the same logic is synthesised into the SoC top.

## Interface
- NUM_CH, 2: number of downstream reset channels (≥1).
- HOLD_CYCLES, 100: cycles all channels stay in reset after synchronised release (≥1).
- STAGGER, 4: cycles between successive channel releases (≥1).
- TIMEOUT_CYCLES, 10000: RUN-phase cycle limit when the watchdog is built (≥2).
- CNT_W, 32: cycle counter width.

Ports:
- clk_init  in  1  system clock.
- rst_init  in  1  reset; asynchronous, active-high.
- soft_rst_i  in  1  synchronous re-sequence request.
- halt_i  in  1  CPU reports end of program.
- rst_n_o  out  NUM_CH  per-channel reset to downstream logic, active-low.
- run_o  out  1  all channels released, in RUN.
- done_o  out  1  halt seen; sticky until reset.
- timeout_o  out  1  watchdog expired; sticky until reset.
- cycle_cnt_o  out  CNT_W  cycles spent in RUN.

## Operation
- States: HOLD, RELEASE, RUN, DONE, TIMEOUT.
- On rst_init asserted (async):
  - State goes to HOLD; counters clear.
  - rst_n_o=0, run_o=0, done_o=0, timeout_o=0, cycle_cnt_o=0.
- rst_init deassertion passes through a 2-flop synchroniser. Assertion bypasses it.
- HOLD: hold counter counts to HOLD_CYCLES, then moves to RELEASE.
- RELEASE: channel k is released at stagger count k*STAGGER. The RUN transition coincides with the last channel's release.
- Released channels stay high until rst_init or soft_rst_i.
- RUN: cycle_cnt_o increments each cycle and saturates at all-ones, with no wrap.
  - halt_i=1 → DONE.
  - Watchdog limit reached → TIMEOUT.
- DONE / TIMEOUT: cycle_cnt_o frozen; channels stay released; run_o=0.
- soft_rst_i=1 in any state except HOLD:
  - Next edge: state=HOLD, all rst_n_o=0, counters and flags cleared.
  - soft_rst_i in HOLD restarts the hold count.
- Priority in one cycle: rst_init > soft_rst_i > halt_i > watchdog.

## Timing
- E0 = second rising clk_init edge after rst_init falls, i.e. the first edge the FSM is out of reset.
- rst_n_o[k] rises at edge E0+HOLD_CYCLES+k*STAGGER.
- run_o rises at edge E0+HOLD_CYCLES+(NUM_CH−1)*STAGGER.
- cycle_cnt_o = 1 after the first RUN edge.
- halt_i sampled high at edge T: done_o=1 and run_o=0 from T, and cycle_cnt_o holds its T value.
- Watchdog: in RUN, if cycle_cnt_o==TIMEOUT_CYCLES−1 at edge T, then timeout_o=1 and state=TIMEOUT at T.
- halt_i at the same edge wins: DONE, timeout_o stays 0.
- rst_init asserted mid-RELEASE or mid-RUN: all rst_n_o=0 within the same delta, not clock-dependent.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- RST_SEQ_WDT_EN defined:
  - Watchdog is active and TIMEOUT is reachable.
- Undefined:
  - TIMEOUT state and comparator are not built.
  - timeout_o is tied 0.
  - TIMEOUT_CYCLES is ignored.
  - RUN exits only via halt_i, soft_rst_i or rst_init.

## Structure
- Shared package rst_seq_pkg: state encoding constants (HOLD=0, RELEASE=1, RUN=2, DONE=3, TIMEOUT=4) and the 3-bit state width.
- One sub-module, rst_sync: 2-flop async-assert / sync-deassert synchroniser on clk_init, rst_init.
- Everything else lives in rst_seq_ctrl.

## Test plan
- **Power-on sequence.** Defaults; rst_init high 1050 ns, then low.
  - rst_n_o[0] rises at E0+100.
  - rst_n_o[1] and run_o rise at E0+104.
  - All outputs are 0 before E0+100.
- **Halt.** halt_i pulsed at RUN cycle 500.
  - done_o=1, run_o=0, cycle_cnt_o frozen at 500.
  - rst_n_o stays 2'b11.
- **Watchdog (RST_SEQ_WDT_EN, TIMEOUT_CYCLES=16).** No halt.
  - timeout_o=1 at RUN cycle 16; cycle_cnt_o=16 thereafter.
  - Without the macro: timeout_o stays 0 and the count continues.
- **Halt/timeout collision.** halt_i asserted at exactly the timeout edge.
  - done_o=1, timeout_o=0.
- **Soft reset from DONE.** soft_rst_i pulsed once.
  - Next edge: rst_n_o=0, done_o=0, cycle_cnt_o=0.
  - Re-release after 100 and 104 cycles.
- **Async reset mid-RELEASE.** NUM_CH=4, STAGGER=3; rst_init asserted between clock edges after channel 1 is released.
  - rst_n_o goes to 0 immediately.
  - The full sequence restarts on release.
